// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg
//   Shared constants for the pipelined wide adder: the default operand width,
//   the number of bits added per pipeline stage, and the stage-count
//   derivation. The RTL and the testbench both use these definitions.
package add_pipe_pkg;

    localparam int DEF_WIDTH = 256;
    localparam int DEF_CHUNK = 64;

    // One pipeline stage per chunk.
    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    localparam int DEF_STAGES = calc_stages(DEF_WIDTH, DEF_CHUNK);

endpackage

// File: rtl/add_chunk.sv
// add_chunk
//   Combinational CHUNK-bit adder slice with carry in and carry out.
//   Ports:
//     a, b  [CHUNK-1:0]  addends
//     cin                carry in
//     sum   [CHUNK-1:0]  a + b + cin, modulo 2^CHUNK
//     cout               carry out of the slice MSB
module add_chunk #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/add_pipe.sv
// add_pipe
//   Pipelined WIDTH-bit adder/subtractor. Each of the STAGES register stages
//   adds one CHUNK-bit slice, carrying into the next stage. Operand chunks
//   that are not yet processed travel alongside, and finished result chunks
//   travel forward. The whole pipe advances together under valid/ready flow
//   control.
//   Ports:
//     clk, rst_n           clock, synchronous active-low reset
//     in_valid, in_ready   input handshake (in_ready = out_ready || !out_valid)
//     a, b [WIDTH-1:0]     operands
//     cin                  carry in (add mode only)
//     sub                  0: a + b + cin, 1: a - b
//     out_valid, out_ready output handshake
//     sum [WIDTH-1:0]      result modulo 2^WIDTH
//     cout                 carry out of MSB (sub mode: 1 = no borrow)
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("add_pipe: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic advance;

    // Stage inputs (from ports for stage 0, from previous registers after).
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];

    // Partial result with this stage's chunk merged in.
    logic [WIDTH-1:0] s_n [STAGES];

    // Stage registers.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic [WIDTH-1:0]  chunk_sum;
    logic [STAGES-1:0] chunk_cout;

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // Subtraction is a + ~b + 1. B is inverted once on entry and carried in
    // that form, so the per-beat mode is fixed at capture time.
    always_comb begin
        a_d[0] = a;
        b_d[0] = sub ? ~b : b;
        c_d[0] = sub ? 1'b1 : cin;
        s_d[0] = '0;
        v_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            c_d[k] = c_q[k-1];
            v_d[k] = v_q[k-1];
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
                .a    (a_d[k][k*CHUNK +: CHUNK]),
                .b    (b_d[k][k*CHUNK +: CHUNK]),
                .cin  (c_d[k]),
                .sum  (chunk_sum[k*CHUNK +: CHUNK]),
                .cout (chunk_cout[k])
            );
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_n[k] = s_d[k];
            s_n[k][k*CHUNK +: CHUNK] = chunk_sum[k*CHUNK +: CHUNK];
        end
    end

    // Only valid bits and the output stage result are reset; the remaining
    // datapath registers are don't-care while their valid bit is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
            end
            s_q[STAGES-1] <= '0;
            c_q[STAGES-1] <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_n[k];
                c_q[k] <= chunk_cout[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe
//   Scoreboard bench for add_pipe: the driver pushes the expected result of
//   every accepted beat, and an independent monitor pops and compares on
//   every output transfer. A second 64/64 instance covers the one-stage case.
module tb_add_pipe;
    import add_pipe_pkg::*;

    localparam int W = DEF_WIDTH;
    localparam int C = DEF_CHUNK;
    localparam int S = DEF_STAGES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    logic        in_valid64;
    logic        in_ready64;
    logic [63:0] a64;
    logic [63:0] b64;
    logic        cin64;
    logic        sub64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] sum64;
    logic        cout64;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    logic       prev_hold = 1'b0;
    logic [W:0] prev_out  = '0;

    add_pipe #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    add_pipe #(.WIDTH(64), .CHUNK(64)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .a         (a64),
        .b         (b64),
        .cin       (cin64),
        .sub       (sub64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .sum       (sum64),
        .cout      (cout64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic; {cout, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
        if (msub)
            return {(ma >= mb), ma - mb};
        return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        int sel;
        sel = $urandom_range(0, 7);
        r = '0;
        if (sel == 0) begin
            r = '1;
        end else if (sel != 1) begin
            for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Call at a falling edge; returns at the falling edge after acceptance
    // with in_valid still high.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
        int n;
        n = 0;
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready) exp_q.push_back(model(ta, tb, tcin, tsub));
        else chk("send_accept", in_ready, 1);
        @(negedge clk);
    endtask

    // Monitor: samples between edges, decoupled from the driver.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            chk("in_ready_advance", in_ready, out_ready || !out_valid);
            if (prev_hold) chk("hold_stable", {cout, sum}, prev_out);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_output", out_valid, 0);
                else chk("result", {cout, sum}, exp_q.pop_front());
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {cout, sum};
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        int lat;
        int n;
        int acc;
        int guard;
        logic [W-1:0] ones;

        ones = '1;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        in_valid64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0;
        out_ready64 = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum_cout", {cout, sum}, 0);
        chk("rst_out_valid64", out_valid64, 0);
        chk("rst_sum64", {cout64, sum64}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_in_ready64", in_ready64, 1);

        // Full carry ripple and latency.
        @(negedge clk);
        out_ready = 1'b1;
        send(ones, '0, 1'b1, 1'b0);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, S);
        chk("ripple_result", {cout, sum}, {1'b1, {W{1'b0}}});
        repeat (2) @(negedge clk);

        // Subtract both ways; cin must be ignored in sub mode.
        send(5, 7, 1'b0, 1'b1);
        send(7, 5, 1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (S + 2) @(negedge clk);

        // Backpressure: 4 beats, then 3 stall cycles once output appears.
        for (int i = 0; i < 4; i++) send(i, i, 1'b0, 1'b0);
        in_valid = 1'b0;
        n = 0;
        #1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_first_valid", out_valid, 1);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #2;
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_held_valid", out_valid, 1);
            chk("bp_held_sum", {cout, sum}, 0);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        repeat (6) @(negedge clk);
        chk("bp_drained", exp_q.size(), 0);

        // Reset with two beats in flight.
        send(1, 2, 1'b0, 1'b0);
        send(3, 4, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        repeat (S + 6) @(negedge clk);

        // Single-stage configuration.
        out_ready64 = 1'b1;
        a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd1; cin64 = 1'b0; sub64 = 1'b0;
        in_valid64 = 1'b1;
        #1;
        chk("c64_in_ready", in_ready64, 1);
        @(negedge clk);
        a64 = 64'd3; b64 = 64'd5; cin64 = 1'b1; sub64 = 1'b1;
        #1;
        chk("c64_valid", out_valid64, 1);
        chk("c64_wrap", {cout64, sum64}, {1'b1, 64'd0});
        @(negedge clk);
        in_valid64 = 1'b0;
        #1;
        chk("c64_sub", {cout64, sum64}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        @(negedge clk);
        #1;
        chk("c64_bubble", out_valid64, 0);
        @(negedge clk);

        // Random traffic.
        acc = 0;
        guard = 0;
        while (acc < 10000 && guard < 80000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = rnd();
            b   = rnd();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                acc++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("random_accepted", acc, 10000);
        chk("random_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter WIDTH, default 256, operand/result width in bits.
REQ-002 Parameter CHUNK, default 64, bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used only in add mode.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-014 cout  output  1  carry-out of MSB (sub mode: 1 = no borrow).

Function
REQ-015 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Pipeline SHALL have STAGES register stages; stage k adds chunk k (bits k*CHUNK+CHUNK-1:k*CHUNK) with carry from stage k-1; unprocessed upper operand chunks travel delayed alongside; lower result chunks travel forward.
REQ-017 Add mode: stage 0 carry-in = cin; sub mode: B inverted per chunk, stage 0 carry-in forced 1, cin ignored.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall.
REQ-019 Throughput one beat per cycle when out_ready held high.
REQ-020 Advance = out_ready || !out_valid; all stages SHALL shift together only when advance=1; otherwise every stage register, valid bit, sum and cout hold.
REQ-021 in_ready SHALL equal advance (combinational from out_ready and out_valid); no combinational path from in_valid to in_ready.
REQ-022 Bubbles (in_valid=0 on advance) SHALL propagate as invalid stages; they are not collapsed.
REQ-023 Results SHALL emerge in input order; none dropped or duplicated.
REQ-024 sum/cout SHALL be stable while out_valid && !out_ready.
REQ-025 STAGES=1 SHALL be legal (latency 1); WIDTH not a multiple of CHUNK is illegal and SHALL fail elaboration.
REQ-026 Per-beat mode: sub and cin SHALL be captured with the beat; mode changes between consecutive beats SHALL not affect in-flight beats.

Reset
REQ-027 While rst_n=0 at a clk edge: all stage valid bits, out_valid, sum and cout SHALL clear to 0; in_ready SHALL read 1 after reset.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; no pre-reset result SHALL ever appear at the output.
REQ-029 Datapath registers other than sum/cout need no reset.

Structure
REQ-030 Shared package/include SHALL hold default WIDTH, CHUNK and the STAGES derivation used by the bench.
REQ-031 One sub-module add_chunk (combinational CHUNK-bit adder: a, b, cin -> sum, cout) SHALL be instantiated once per stage.

Verification (WIDTH=256, CHUNK=64, STAGES=4 unless noted)
REQ-032 Full ripple: a=all ones, b=0, cin=1, sub=0, out_ready=1 -> 4 cycles later sum=0, cout=1.
REQ-033 Subtract: a=5, b=7, sub=1 -> sum=2^256-2, cout=0; a=7, b=5 -> sum=2, cout=1.
REQ-034 Backpressure: 4 back-to-back beats (a=i, b=i, cin=0), out_ready=0 for 3 cycles after first out_valid -> in_ready=0 same cycles, sum=0 held stable, then outputs 0,2,4,6 in order with no loss.
REQ-035 Reset mid-flight: 2 beats accepted, rst_n=0 one cycle -> out_valid=0 following cycle, no result for those beats ever emitted.
REQ-036 Config WIDTH=CHUNK=64: a=2^64-1, b=1, cin=0 -> next cycle sum=0, cout=1.
REQ-037 Random: 10k beats, random in_valid/out_ready, mixed sub/cin, checked against reference model A+B+cin or A-B mod 2^WIDTH with cout.
